// File: rtl/sys_bus_mux_if.sv
// Bus bundle between one CPU master, the sys_bus_mux and NUM_SLV slaves.
// The mux takes the slave modport; the CPU/slave environment takes the master modport.
interface sys_bus_mux_if #(
    parameter int NUM_SLV = 4
);
    logic [31:0]           cpu_addr;
    logic                  cpu_valid;
    logic                  cpu_wen;
    logic [31:0]           cpu_wdata;
    logic [3:0]            cpu_wmask;
    logic [31:0]           cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_err;
    logic [NUM_SLV-1:0]    slv_valid;
    logic                  slv_wen;
    logic [27:0]           slv_addr;
    logic [31:0]           slv_wdata;
    logic [3:0]            slv_wmask;
    logic [32*NUM_SLV-1:0] slv_rdata;
    logic [NUM_SLV-1:0]    slv_ready;
    logic                  err_clr;
    logic [31:0]           err_addr;
    logic [7:0]            err_cnt;

    modport slave (
        input  cpu_addr, cpu_valid, cpu_wen, cpu_wdata, cpu_wmask,
        input  slv_rdata, slv_ready, err_clr,
        output cpu_rdata, cpu_ready, cpu_err,
        output slv_valid, slv_wen, slv_addr, slv_wdata, slv_wmask,
        output err_addr, err_cnt
    );

    modport master (
        output cpu_addr, cpu_valid, cpu_wen, cpu_wdata, cpu_wmask,
        output slv_rdata, slv_ready, err_clr,
        input  cpu_rdata, cpu_ready, cpu_err,
        input  slv_valid, slv_wen, slv_addr, slv_wdata, slv_wmask,
        input  err_addr, err_cnt
    );
endinterface

// File: rtl/sys_bus_mux.sv
// Single-master to NUM_SLV-slave bus mux: address decode on [31:28], per-access
// timeout, registered response and sticky error status (address + saturating count).
module sys_bus_mux #(
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    sys_bus_mux_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_p0;
    logic        wen_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  wmask_p0;
    logic [15:0] tmo_cnt;
    logic        err_p1;
    logic [31:0] rdata_p1;
    logic [31:0] err_addr_q;
    logic [7:0]  err_cnt_q;

    logic [3:0]  req_idx;
    logic [3:0]  cur_idx;
    logic        decode_ok;
    logic        tmo_hit;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign req_idx   = bus.cpu_addr[31:28];
    assign cur_idx   = addr_p0[31:28];
    assign decode_ok = ({1'b0, req_idx} < 5'(NUM_SLV));
    assign tmo_hit   = (tmo_cnt == 16'(TIMEOUT));

    // Only the selected slave's ready/rdata are visible to the FSM.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (cur_idx == 4'(i)) begin
                sel_ready = bus.slv_ready[i];
                sel_rdata = bus.slv_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        bus.slv_valid = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            bus.slv_valid[i] = (state == ACCESS) && (cur_idx == 4'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cpu_valid) state_nxt = decode_ok ? ACCESS : RESP;
            ACCESS:  if (sel_ready || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: request latch; stage p1: response (error flag and read data).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_p0  <= '0;
            wen_p0   <= 1'b0;
            wdata_p0 <= '0;
            wmask_p0 <= '0;
            tmo_cnt  <= '0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.cpu_valid) begin
                        addr_p0  <= bus.cpu_addr;
                        wen_p0   <= bus.cpu_wen;
                        wdata_p0 <= bus.cpu_wdata;
                        wmask_p0 <= bus.cpu_wmask;
                        tmo_cnt  <= '0;
                        err_p1   <= !decode_ok;
                        if (!decode_ok && !bus.cpu_wen) rdata_p1 <= '0;
                    end
                end
                ACCESS: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (sel_ready) begin
                        err_p1 <= 1'b0;
                        if (!wen_p0) rdata_p1 <= sel_rdata;
                    end else if (tmo_hit) begin
                        err_p1 <= 1'b1;
                        if (!wen_p0) rdata_p1 <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A clear that coincides with an errored response still records that error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else if (state == RESP && err_p1) begin
            err_addr_q <= addr_p0;
            err_cnt_q  <= bus.err_clr ? 8'd1 : sat_inc(err_cnt_q);
        end else if (bus.err_clr) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end
    end

    assign bus.cpu_ready = (state == RESP);
    assign bus.cpu_err   = (state == RESP) && err_p1;
    assign bus.cpu_rdata = rdata_p1;
    assign bus.slv_wen   = wen_p0;
    assign bus.slv_addr  = addr_p0[27:0];
    assign bus.slv_wdata = wdata_p0;
    assign bus.slv_wmask = wmask_p0;
    assign bus.err_addr  = err_addr_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule
